// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier with signed/unsigned mode.
//   The multiplicand is Booth-encoded. The multiplier is selected and shifted for each digit.
//   DPC digits are retired per cycle.
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   in_valid/in_ready           operand handshake (accepted only in IDLE)
//   in_mltpcd, in_mltplr        operands, WIDTH bits each
//   in_signed                   1 = two's-complement operands, 0 = unsigned
//   out_valid/out_ready         result handshake
//   out_product                 2*WIDTH-bit product, held stable while out_valid
module booth_mult_seq #(
    parameter int WIDTH = 64,
    parameter int DPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mltpcd,
    input  logic [WIDTH-1:0]     in_mltplr,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);

    localparam int EW   = WIDTH + 2;
    localparam int ND   = EW / 2;
    localparam int NCYC = (ND + DPC - 1) / DPC;
    localparam int AW   = 2*WIDTH + 2;
    // The counter overshoots ND by up to DPC-1 after the last CALC cycle.
    localparam int CW   = $clog2(NCYC*DPC + 1);
    // Zero padding above the operand keeps every digit window in range,
    // including windows past the last real digit.
    localparam int AXW  = EW + 1 + 4*DPC;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] ONE_AW = AW'(1);

    logic [1:0]         state_q, state_d;
    logic [EW-1:0]      a_q, a_d;
    logic [EW-1:0]      m_q, m_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               vld_q, vld_d;

    logic [AXW-1:0]     a_x;
    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      pp_sum;
    logic [2:0]         dig;
    int                 k;

    // Sum of the DPC shifted partial products for digits cnt_q .. cnt_q+DPC-1.
    always_comb begin
        a_x    = {{(AXW-EW-1){1'b0}}, a_q, 1'b0};     // a[-1] = 0
        m_ext  = {{(AW-EW){m_q[EW-1]}}, m_q};
        pp_sum = '0;
        pp     = '0;
        dig    = 3'b000;
        k      = 0;
        for (int j = 0; j < DPC; j++) begin
            k   = int'(cnt_q) + j;
            dig = (k < ND) ? a_x[2*k +: 3] : 3'b000;
            case (dig)
                3'b001, 3'b010: pp = m_ext;
                3'b011:         pp = m_ext << 1;
                3'b100:         pp = ~(m_ext << 1) + ONE_AW;
                3'b101, 3'b110: pp = ~m_ext + ONE_AW;
                default:        pp = '0;
            endcase
            pp_sum = pp_sum + (pp << (2*k));
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = {{2{in_signed & in_mltpcd[WIDTH-1]}}, in_mltpcd};
                    m_d     = {{2{in_signed & in_mltplr[WIDTH-1]}}, in_mltplr};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Once every digit is retired, spend one cycle capturing the result.
                if (int'(cnt_q) >= ND) begin
                    prod_d  = acc_q[2*WIDTH-1:0];
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q + pp_sum;
                    cnt_d = cnt_q + CW'(DPC);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = vld_q;
    assign out_product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for a 64-bit/DPC=1 instance and a 16-bit/DPC=3 instance.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 64-bit, DPC=1 instance
    logic         v64 = 1'b0, r64, s64 = 1'b0, ov64, or64 = 1'b0;
    logic [63:0]  a64 = '0, b64 = '0;
    logic [127:0] p64;

    // 16-bit, DPC=3 instance
    logic         v16 = 1'b0, r16, s16 = 1'b0, ov16, or16 = 1'b0;
    logic [15:0]  a16 = '0, b16 = '0;
    logic [31:0]  p16;

    booth_mult_seq #(.WIDTH(64), .DPC(1)) u64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
        .in_mltpcd(a64), .in_mltplr(b64), .in_signed(s64),
        .out_valid(ov64), .out_ready(or64), .out_product(p64)
    );

    booth_mult_seq #(.WIDTH(16), .DPC(3)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .in_mltpcd(a16), .in_mltplr(b16), .in_signed(s16),
        .out_valid(ov16), .out_ready(or16), .out_product(p16)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] sb64[$];
    logic [31:0]  sb16[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input bit s);
        logic [31:0] x, y;
        x = s ? {{16{a[15]}}, a} : {16'b0, a};
        y = s ? {{16{b[15]}}, b} : {16'b0, b};
        return x * y;
    endfunction

    // Offer one operand set to the 64-bit instance, scramble the inputs after accept,
    // then check latency, product and (optionally) backpressure hold.
    task automatic op64(input logic [63:0] a, input logic [63:0] b, input bit s,
                        input logic [127:0] exp, input int hold);
        int lat;
        logic [127:0] held;
        @(negedge clk);
        chk("in_ready_idle64", r64, 1);
        a64 = a; b64 = b; s64 = s; v64 = 1'b1;
        sb64.push_back(exp);
        @(posedge clk); #1;
        v64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; s64 = ~s;
        lat = 0;
        while (!ov64 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) chk("in_ready_calc64", r64, 0);
        end
        chk("latency64", lat, 34);
        if (sb64.size() > 0) held = sb64.pop_front(); else held = '0;
        if (ov64) begin
            chk("product64", p64, held);
            held = p64;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_stable64", p64, held);
                chk("hold_valid64", ov64, 1);
                chk("hold_in_ready64", r64, 0);
            end
        end
        or64 = 1'b1;
        @(posedge clk); #1;
        or64 = 1'b0;
        chk("release_valid64", ov64, 0);
        chk("release_ready64", r64, 1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit s);
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        chk("in_ready_idle16", r16, 1);
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        sb16.push_back(ref16(a, b, s));
        @(posedge clk); #1;
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
        lat = 0;
        while (!ov16 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency16", lat, 4);
        if (sb16.size() > 0) exp = sb16.pop_front(); else exp = '0;
        chk("product16", p16, exp);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        chk("release_valid16", ov16, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [15:0] ca [4];
        ca[0] = 16'h8000; ca[1] = 16'hFFFF; ca[2] = 16'h0000; ca[3] = 16'h7FFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready64", r64, 1);
        chk("rst_out_valid64", ov64, 0);
        chk("rst_product64", p64, 0);
        chk("rst_in_ready16", r16, 1);
        chk("rst_out_valid16", ov16, 0);
        rst = 1'b0;

        // -1 * -1 signed
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'h1, 0);
        // full-range unsigned
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);
        // most-negative squared, signed and unsigned
        op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, 0);
        op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, 0);
        // zero operand, with 10 cycles of backpressure
        op64(64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, 128'h0, 10);
        // mixed signs with backpressure: 0x1234 * -1
        op64(64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_EDCC, 10);

        // reset in the middle of CALC: the aborted operation must never surface
        @(negedge clk);
        a64 = 64'h0123_4567_89AB_CDEF; b64 = 64'h0FED_CBA9_8765_4321; s64 = 1'b0; v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready64", r64, 1);
        chk("midrst_out_valid64", ov64, 0);
        chk("midrst_product64", p64, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov64) seen++;
        end
        chk("midrst_no_result64", seen, 0);
        op64(64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 0);

        // 16-bit, 3 digits per cycle: corners then random pairs
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                op16(ca[i], ca[j], 1'b1);
                op16(ca[i], ca[j], 1'b0);
            end
        for (int i = 0; i < 2000; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        chk("sb64_drained", sb64.size(), 0);
        chk("sb16_drained", sb16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
